// File: rtl/data_memory_if.sv
// Bus bundle for the calculator data memory: write enable, shared address,
// write data and combinational read data.
interface data_memory_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9
);
    // No handshake: a write is taken on every rising edge with EN high, and
    // OUT always reflects mem[ADDR] with no valid/ready qualification.
    logic                         EN;
    logic [ADDR_WIDTH-1:0]        ADDR;
    logic signed [DATA_WIDTH-1:0] IN;
    logic signed [DATA_WIDTH-1:0] OUT;

    modport master (output EN, output ADDR, output IN, input OUT);
    modport slave  (input EN, input ADDR, input IN, output OUT);
endinterface

// File: rtl/data_memory.sv
// 512 x 16 signed register-file memory: synchronous write, combinational
// read, single-cycle synchronous clear that takes priority over writes.
module data_memory #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 9,
    parameter int DEPTH      = 2 ** ADDR_WIDTH
) (
    input logic           CLK,
    input logic           RST,
    data_memory_if.slave  bus
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] mem_d [DEPTH];

    always_comb begin
        mem_d = mem_q;
        if (bus.EN) begin
            mem_d[bus.ADDR] = bus.IN;
        end
    end

    // Reset wins over EN, so a write presented during reset is dropped.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_q <= '{default: '0};
        end else begin
            mem_q <= mem_d;
        end
    end

    assign bus.OUT = mem_q[bus.ADDR];

endmodule

// File: tb/tb_data_memory.sv
// Directed plus random checks of data_memory against a reference array,
// using an expected-value queue drained by an independent monitor.
module tb_data_memory;

  localparam int DW = 16;
  localparam int AW = 9;
  localparam int DEPTH = 512;

  logic clk;
  logic rst;

  data_memory_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  data_memory #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .CLK (clk),
    .RST (rst),
    .bus (bus)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard state
  logic [DW-1:0] exp_q[$];
  string         name_q[$];
  logic          chk_vld;
  int            total;
  int            bad;
  logic [DW-1:0] model [DEPTH];

  // monitor: compares OUT on the falling edge whenever a read is presented
  always @(negedge clk) begin
    if (chk_vld) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_read: out=%h with empty expected queue", bus.OUT);
      end else begin
        logic [DW-1:0] e;
        string n;
        e = exp_q.pop_front();
        n = name_q.pop_front();
        if (bus.OUT !== e) begin
          bad++;
          $display("FAIL %s: addr=%0d out=%h expected=%h", n, bus.ADDR, bus.OUT, e);
        end
      end
    end
  end

  // driver tasks: inputs change #1 after the rising edge
  task automatic do_reset(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
    rst = 1'b1;
    bus.EN = en;
    bus.ADDR = a;
    bus.IN = d;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.EN = 1'b0;
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.EN = 1'b1;
    bus.ADDR = a;
    bus.IN = d;
    @(posedge clk);
    #1;
    bus.EN = 1'b0;
    model[a] = d;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [DW-1:0] e, input string n);
    bus.EN = 1'b0;
    bus.ADDR = a;
    exp_q.push_back(e);
    name_q.push_back(n);
    chk_vld = 1'b1;
    @(negedge clk);
    @(posedge clk);
    #1;
    chk_vld = 1'b0;
  endtask

  initial begin
    total = 0;
    bad = 0;
    chk_vld = 1'b0;
    rst = 1'b0;
    bus.EN = 1'b0;
    bus.ADDR = '0;
    bus.IN = '0;
    @(posedge clk);
    #1;

    // reset clears every word
    do_reset(1'b0, '0, '0);
    for (int i = 0; i < DEPTH; i++) do_read(AW'(i), 16'h0000, "reset_sweep");

    // basic write then hold with EN low
    do_write(9'd123, 16'd456);
    do_read(9'd123, 16'd456, "write_123");
    bus.EN = 1'b0;
    bus.ADDR = 9'd123;
    bus.IN = 16'd999;
    @(posedge clk);
    @(posedge clk);
    #1;
    do_read(9'd123, 16'd456, "hold_123");
    do_read(9'd124, 16'h0000, "neighbour_124");

    // signed extremes at the boundary addresses
    do_write(9'd0, 16'h8000);
    do_write(9'd511, 16'h7FFF);
    do_read(9'd0, 16'h8000, "min_at_0");
    do_read(9'd511, 16'h7FFF, "max_at_511");
    do_read(9'd0, 16'h8000, "toggle_0");
    do_read(9'd511, 16'h7FFF, "toggle_511");
    do_write(9'd200, 16'hFFFF);
    do_read(9'd200, 16'hFFFF, "minus_one");

    // reset beats a simultaneous write
    do_reset(1'b1, 9'd5, 16'd77);
    do_read(9'd5, 16'h0000, "rst_prio_5");
    do_read(9'd123, 16'h0000, "rst_clears_123");
    do_read(9'd511, 16'h0000, "rst_clears_511");

    // back-to-back writes: last one wins, neighbours untouched
    do_write(9'd300, 16'd10);
    do_write(9'd300, 16'd20);
    do_read(9'd300, 16'd20, "overwrite_300");
    do_read(9'd299, 16'h0000, "neighbour_299");
    do_read(9'd301, 16'h0000, "neighbour_301");

    // random writes and reads against the reference array
    for (int i = 0; i < 1000; i++) begin
      logic [AW-1:0] a;
      a = AW'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, DW'($urandom_range(0, 65535)));
      end else begin
        do_read(a, model[a], "random_read");
      end
    end
    for (int i = 0; i < 32; i++) begin
      logic [AW-1:0] a;
      a = AW'(i * 16);
      do_read(a, model[a], "final_sweep");
    end

    @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL queue_drain: left=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/data_memory.md
Name: data_memory

Overview:
- Single-port 512 x 16 signed data memory for the pocket-calculator datapath.
- Holds operands and results.
- Written synchronously when EN is high; read combinationally at all times from the location selected by ADDR.
- A synchronous reset clears the whole array.

Parameters:
- DATA_WIDTH, 16: word width in bits; data is two's-complement signed.
- ADDR_WIDTH, 9: address width in bits.
- DEPTH, 512: number of words; equals 2**ADDR_WIDTH.

Ports:
- CLK  input  1  system clock; all state changes on its rising edge.
- RST  input  1  synchronous, active-high reset.
- EN  input  1  write enable; active high.
- ADDR  input  9  word address, 0..511; used for both read and write.
- IN  input  16 (signed)  write data.
- OUT  output  16 (signed)  read data = contents of mem[ADDR].

Behaviour:
- Storage: array of DEPTH words of DATA_WIDTH bits, implemented as registers (no vendor RAM macro required).
- Reset:
  - On a rising CLK edge with RST=1, every location 0..511 is set to 0 in that single cycle.
  - RST has priority over EN: no write occurs in a reset cycle.
  - After a reset edge, OUT = 0 for every ADDR.
- Write:
  - On a rising CLK edge with RST=0 and EN=1, mem[ADDR] <= IN.
  - Write latency is 1 edge.
  - Only the addressed location changes.
- Hold: with RST=0 and EN=0, contents are unchanged on every edge.
- Read:
  - OUT = mem[ADDR] combinationally, with no read latency and no dependence on EN.
  - A change on ADDR is reflected on OUT within the same cycle.
  - After a write edge, OUT shows the newly written value immediately (write-first as seen from OUT).
- Contents before the first reset are undefined (X in simulation); verification must reset first.
- Width rules:
  - IN is stored bit-exact; no sign extension, truncation or arithmetic.
  - Negative values round-trip unchanged, e.g. -1 is stored as 16'hFFFF.
- Address range: the full 9-bit range is valid, so there is no out-of-range case.
  - Address 0 and address 511 behave identically to all other addresses.
- Simultaneous events:
  - RST=1 and EN=1 on the same edge: the memory clears and IN is discarded.
  - Back-to-back writes to the same address: the last write wins.
- No handshake, no busy/ready signals; a new write is accepted every cycle.

Test Plan:
- Reset: hold RST=1 for 1 edge, then RST=0, sweep ADDR 0..511 -> OUT = 0 at every address.
- Write/read:
  - RST=0, EN=1, ADDR=123, IN=456, 1 edge -> OUT=456.
  - Then EN=0, IN=999 for 2 edges, keep ADDR=123 -> OUT stays 456.
  - ADDR=124 -> OUT=0.
- Signed and boundary addresses:
  - Write -32768 to address 0 and 32767 to address 511.
  - Read back -> exact values; OUT changes combinationally when ADDR toggles between 0 and 511.
- Reset priority: RST=1, EN=1, ADDR=5, IN=77 on one edge -> OUT at ADDR 5 = 0, and previously written address 123 now reads 0.
- Overwrite: write 10 then 20 to ADDR=300 on consecutive edges -> OUT=20; neighbours 299 and 301 are unaffected (0).
- Random: 1000 random writes/reads checked against a reference model array -> zero mismatches.
